// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer.
// One aluslice instance processes the operands one bit per cycle, LSB first.
// The slice carry-out is held in a register and fed back as the next bit's
// carry-in. After WIDTH bit-cycles the result, zero, carry and overflow are
// published and held.

// One-bit ALU slice with optional input inversion.
// sel: 0/1 sum, 2 xor, 3 sum (set-less-than fix-up happens in the sequencer),
// 4/6 nor, 5/7 nand. With both inputs inverted, nor gives AND and nand gives OR.
module aluslice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       invta,
    input  logic       invtb,
    input  logic [2:0] sel,
    output logic       result,
    output logic       cout
);

    logic ai;
    logic bi;
    logic sum;

    // Conditional inversion, full adder and per-opcode result mux.
    always_comb begin
        ai   = a ^ invta;
        bi   = b ^ invtb;
        sum  = ai ^ bi ^ cin;
        cout = (ai & bi) | (ai & cin) | (bi & cin);
        unique case (sel)
            3'd0, 3'd1, 3'd3: result = sum;
            3'd2:             result = ai ^ bi;
            3'd4, 3'd6:       result = ~(ai | bi);
            default:          result = ~(ai & bi);
        endcase
    end

endmodule

module serial_alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carryout,
    output logic             overflow
);

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_SLT = 3'd3;
    localparam logic [2:0] CMD_AND = 3'd4;
    localparam logic [2:0] CMD_OR  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [2:0]        cmd_reg;
    logic              carry_reg;
    logic [CNTW-1:0]   idx_reg;
    logic [WIDTH-1:0]  shift_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              zero_reg;
    logic              carryout_reg;
    logic              overflow_reg;

    logic              accept;
    logic              last_bit;
    logic              slice_invta;
    logic              slice_invtb;
    logic              slice_res;
    logic              slice_cout;
    logic              carry_init;
    logic              ovf_raw;
    logic [WIDTH-1:0]  final_res;

    // Slice controls come from the latched opcode so input changes mid-run are harmless.
    always_comb begin
        slice_invta = (cmd_reg == CMD_AND) || (cmd_reg == CMD_OR);
        slice_invtb = (cmd_reg == CMD_SUB) || (cmd_reg == CMD_SLT) ||
                      (cmd_reg == CMD_AND) || (cmd_reg == CMD_OR);
        carry_init  = (cmd == CMD_SUB) || (cmd == CMD_SLT);
    end

    aluslice u_slice (
        .a      (a_reg[idx_reg]),
        .b      (b_reg[idx_reg]),
        .cin    (carry_reg),
        .invta  (slice_invta),
        .invtb  (slice_invtb),
        .sel    (cmd_reg),
        .result (slice_res),
        .cout   (slice_cout)
    );

    // Final-bit bookkeeping: MSB carry-in is the carry register during the last bit.
    always_comb begin
        accept    = start && (state_reg != S_RUN);
        last_bit  = (state_reg == S_RUN) && (idx_reg == CNTW'(WIDTH - 1));
        ovf_raw   = carry_reg ^ slice_cout;
        final_res = shift_reg;
        final_res[WIDTH-1] = slice_res;
        if (cmd_reg == CMD_SLT) begin
            final_res = {{(WIDTH-1){1'b0}}, slice_res ^ ovf_raw};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
            default: state_next = accept ? S_RUN : S_IDLE;
        endcase
    end

    // Operand latch, bit-serial datapath and flag publication.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            cmd_reg      <= '0;
            carry_reg    <= 1'b0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            carryout_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            cmd_reg   <= cmd;
            carry_reg <= carry_init;
            idx_reg   <= '0;
            shift_reg <= '0;
        end else if (state_reg == S_RUN) begin
            shift_reg[idx_reg] <= slice_res;
            carry_reg          <= slice_cout;
            idx_reg            <= idx_reg + 1'b1;
            if (last_bit) begin
                result_reg   <= final_res;
                zero_reg     <= (final_res == '0);
                carryout_reg <= ((cmd_reg == CMD_ADD) || (cmd_reg == CMD_SUB)) & slice_cout;
                overflow_reg <= ((cmd_reg == CMD_ADD) || (cmd_reg == CMD_SUB) ||
                                 (cmd_reg == CMD_SLT)) & ovf_raw;
            end
        end
    end

    assign busy     = (state_reg == S_RUN);
    assign done     = (state_reg == S_DONE);
    assign result   = result_reg;
    assign zero     = zero_reg;
    assign carryout = carryout_reg;
    assign overflow = overflow_reg;

endmodule
